// File: rtl/super_alu_sequencer_pkg.sv
// Shared types and instruction-field layout for the super-ALU sequencer.
package super_alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } state_t;

    localparam int OP_MSB      = 47;
    localparam int OP_LSB      = 39;
    localparam int SEL_POS [4] = '{38, 29, 20, 11};
    localparam int NUM_LSB [4] = '{30, 21, 12, 3};
    localparam int DEST_MSB    = 2;
    localparam int ALU_IN_W    = 41;

    // Lowest register-sourced slot at or above start: {found, slot}.
    function automatic logic [2:0] find_sel(input logic [3:0] sel, input logic [2:0] start);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (sel[i] && (i >= int'(start))) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/super_alu_sequencer_regfile.sv
// Register file owned by the sequencer: one write port, async fetch and debug reads.
module seq_regfile #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [15:0]   i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_byte,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [15:0]   o_dbg_data
);

    logic [15:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Operands are 8 bits wide, so the fetch port only exposes the low byte.
    assign o_rd_byte  = r_mem[i_rd_addr][7:0];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/super_alu_sequencer.sv
// Sequences one super-ALU instruction at a time: operand fetch, ALU wait, writeback, result handshake.
module super_alu_sequencer
    import super_alu_pkg::*;
#(
    parameter int ALU_LATENCY = 1,
    parameter int REG_DEPTH   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [47:0]         in_instr,
    output logic [ALU_IN_W-1:0] alu_in,
    input  logic [15:0]         alu_out,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [15:0]         res_data,
    output logic [2:0]          res_addr,
    output logic                busy,
    input  logic [2:0]          dbg_addr,
    output logic [15:0]         dbg_data
);

    localparam int AW    = $clog2(REG_DEPTH);
    localparam int LAT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LATENCY - 1);

    state_t                r_state;
    logic [8:0]            r_op;
    logic [3:0]            r_sel;
    logic [AW-1:0]         r_src [4];
    logic [DEST_MSB:0]     r_dest;
    logic [7:0]            r_opnd [4];
    logic [1:0]            r_slot;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic [ALU_IN_W-1:0]   r_alu_in;
    logic [15:0]           r_res_data;
    logic [2:0]            r_res_addr;
    logic                  r_res_valid;

    logic [3:0]            w_sel_in;
    logic [7:0]            w_num_in [4];
    logic [7:0]            w_opnd_next [4];
    logic [2:0]            w_first;
    logic [2:0]            w_next;
    logic [7:0]            w_fetch_byte;
    logic                  w_wr_en;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign w_sel_in[gi] = in_instr[SEL_POS[gi]];
            assign w_num_in[gi] = in_instr[NUM_LSB[gi] +: 8];
            // Operand set as it will look after this cycle's fetch lands.
            assign w_opnd_next[gi] = (r_state == FETCH && r_slot == 2'(gi)) ? w_fetch_byte : r_opnd[gi];
        end
    endgenerate

    assign w_first = find_sel(w_sel_in, 3'd0);
    assign w_next  = find_sel(r_sel, {1'b0, r_slot} + 3'd1);
    // Write exactly once: on the WB cycle before res_valid rises.
    assign w_wr_en = (r_state == WB) && !r_res_valid;

    seq_regfile #(
        .DEPTH (REG_DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (r_dest[AW-1:0]),
        .i_wr_data  (r_res_data),
        .i_rd_addr  (r_src[r_slot]),
        .o_rd_byte  (w_fetch_byte),
        .i_dbg_addr (dbg_addr[AW-1:0]),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_sel       <= '0;
            r_dest      <= '0;
            r_slot      <= '0;
            r_lat_cnt   <= '0;
            r_alu_in    <= '0;
            r_res_data  <= '0;
            r_res_addr  <= '0;
            r_res_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_src[i]  <= '0;
                r_opnd[i] <= '0;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op   <= in_instr[OP_MSB:OP_LSB];
                        r_sel  <= w_sel_in;
                        r_dest <= in_instr[DEST_MSB:0];
                        for (int i = 0; i < 4; i++) begin
                            r_src[i]  <= w_num_in[i][AW-1:0];
                            r_opnd[i] <= w_sel_in[i] ? 8'd0 : w_num_in[i];
                        end
                        if (w_first[2]) begin
                            r_slot  <= w_first[1:0];
                            r_state <= FETCH;
                        end else begin
                            r_alu_in  <= {in_instr[OP_MSB:OP_LSB], w_num_in[0], w_num_in[1],
                                          w_num_in[2], w_num_in[3]};
                            r_lat_cnt <= '0;
                            r_state   <= EXEC;
                        end
                    end
                end
                FETCH: begin
                    for (int i = 0; i < 4; i++) begin
                        r_opnd[i] <= w_opnd_next[i];
                    end
                    if (w_next[2]) begin
                        r_slot <= w_next[1:0];
                    end else begin
                        r_alu_in  <= {r_op, w_opnd_next[0], w_opnd_next[1],
                                      w_opnd_next[2], w_opnd_next[3]};
                        r_lat_cnt <= '0;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        r_res_data <= alu_out;
                        r_state    <= WB;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                WB: begin
                    if (!r_res_valid) begin
                        r_res_valid <= 1'b1;
                        r_res_addr  <= 3'(r_dest);
                    end else if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign alu_in    = r_alu_in;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_addr  = r_res_addr;

endmodule

// File: tb/tb_super_alu_sequencer.sv
// Bench for super_alu_sequencer: fixed vectors, random instructions vs. a register-file model, and corner sequences.
module tb_super_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] in_instr = '0;
    logic [40:0] alu_in;
    logic [15:0] alu_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic [2:0]  res_addr;
    logic        busy;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_txn = 0;
    logic [15:0] m_regs [8];

    always #5 clk = ~clk;

    // External combinational super_alu stand-in.
    function automatic logic [15:0] alu_f(input logic [40:0] x);
        logic [7:0] a, b, c, d;
        {a, b, c, d} = x[31:0];
        case (x[33:32])
            2'd0:    return 16'(a) + 16'(b) + 16'(c) + 16'(d);
            2'd1:    return 16'(a) * 16'(b) * 16'(d);
            2'd2:    return {a, b} ^ {c, d};
            default: return {a, b};
        endcase
    endfunction

    assign alu_out = alu_f(alu_in);

    super_alu_sequencer #(.ALU_LATENCY(1), .REG_DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .alu_in    (alu_in),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_addr  (res_addr),
        .busy      (busy),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    function automatic logic [47:0] mk(input logic [8:0] op, input logic [3:0] s,
                                       input logic [7:0] n0, input logic [7:0] n1,
                                       input logic [7:0] n2, input logic [7:0] n3,
                                       input logic [2:0] dest);
        return {op, s[0], n0, s[1], n1, s[2], n2, s[3], n3, dest};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: operands from the model register file, latency 1 + Nreg + ALU_LATENCY.
    task automatic model_expect(input logic [47:0] ins, output logic [15:0] d,
                                output int lat, output logic [40:0] ai);
        logic [7:0] ops [4];
        logic [7:0] num;
        int nreg;
        nreg = 0;
        for (int k = 0; k < 4; k++) begin
            num = ins[37-9*k -: 8];
            if (ins[38-9*k]) begin
                ops[k] = m_regs[num[2:0]][7:0];
                nreg++;
            end else begin
                ops[k] = num;
            end
        end
        ai  = {ins[47:39], ops[0], ops[1], ops[2], ops[3]};
        d   = alu_f(ai);
        lat = 1 + nreg + 1;
    endtask

    task automatic start(input logic [47:0] ins, input bit hold);
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        in_instr = ins;
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic collect(input logic [47:0] ins, input logic [15:0] ed, input int el,
                           input logic [40:0] ea, input int stall);
        int cyc;
        logic [40:0] snap;
        logic [2:0] dest;
        bit rdy_bad, stab_bad;
        cyc = 0;
        snap = '0;
        rdy_bad = 1'b0;
        stab_bad = 1'b0;
        dest = ins[2:0];
        while (!res_valid && cyc < 60) begin
            if (cyc == el - 2) snap = alu_in;
            if (in_ready) rdy_bad = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(el));
        chk("alu_in", 64'(snap), 64'(ea));
        chk("res_data", 64'(res_data), 64'(ed));
        chk("res_addr", 64'(res_addr), 64'(dest));
        chk("in_ready_low_busy", 64'(rdy_bad), 64'd0);
        dbg_addr = dest;
        #1;
        chk("dbg_after_wb", 64'(dbg_data), 64'(ed));
        repeat (stall) begin
            @(posedge clk); #1;
            if (!res_valid || res_data !== ed || res_addr !== dest || in_ready || dbg_data !== ed)
                stab_bad = 1'b1;
        end
        if (stall > 0) chk("stall_stable", 64'(stab_bad), 64'd0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("res_valid_drop", 64'(res_valid), 64'd0);
        chk("in_ready_after", 64'(in_ready), 64'd1);
        m_regs[dest] = ed;
        $display("txn %0d instr=%h dest=%0d res=%h lat=%0d stall=%0d", n_txn, ins, dest, res_data, cyc, stall);
        n_txn++;
    endtask

    typedef struct {
        logic [47:0] ins;
        logic [15:0] exp_d;
        int          exp_lat;
        logic [40:0] exp_ai;
        int          stall;
    } vec_t;

    vec_t vt [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] ins, ins_b;
        logic [15:0] ed;
        int el;
        logic [40:0] ea;

        for (int r = 0; r < 8; r++) m_regs[r] = '0;

        vt[0] = '{mk(9'h005, 4'b0000, 8'd12, 8'd6, 8'd2, 8'd4, 3'd0), 16'd288, 2,
                  {9'h005, 8'd12, 8'd6, 8'd2, 8'd4}, 0};
        vt[1] = '{mk(9'h003, 4'b0000, 8'h12, 8'h34, 8'h00, 8'h00, 3'd1), 16'h1234, 2,
                  {9'h003, 8'h12, 8'h34, 8'h00, 8'h00}, 0};
        vt[2] = '{mk(9'h000, 4'b0001, 8'h09, 8'h01, 8'h02, 8'h03, 3'd2), 16'h003A, 3,
                  {9'h000, 8'h34, 8'h01, 8'h02, 8'h03}, 0};
        vt[3] = '{mk(9'h000, 4'b1111, 8'h01, 8'hF8, 8'h02, 8'h01, 3'd1), 16'h00C2, 6,
                  {9'h000, 8'h34, 8'h20, 8'h3A, 8'h34}, 0};
        vt[4] = '{mk(9'h002, 4'b1001, 8'h01, 8'h0F, 8'hFF, 8'h02, 3'd3), 16'h3D35, 4,
                  {9'h002, 8'hC2, 8'h0F, 8'hFF, 8'h3A}, 5};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_alu_in", 64'(alu_in), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_res_addr", 64'(res_addr), 64'd0);
        chk("rst_dbg0", 64'(dbg_data), 64'd0);

        // Fixed vectors: immediates, single fetch, 4 fetches with dest==src, stall in WB
        for (int i = 0; i < 5; i++) begin
            start(vt[i].ins, 1'b0);
            collect(vt[i].ins, vt[i].exp_d, vt[i].exp_lat, vt[i].exp_ai, vt[i].stall);
        end

        // Random instructions against the model
        for (int i = 0; i < 24; i++) begin
            ins = mk(9'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                     8'($urandom), 8'($urandom), 3'($urandom));
            model_expect(ins, ed, el, ea);
            start(ins, 1'b0);
            collect(ins, ed, el, ea, int'($urandom_range(0, 2)));
        end

        // Back-to-back: B reads A's dest while in_valid stays high
        ins   = mk(9'h003, 4'b0000, 8'hAB, 8'hCD, 8'h00, 8'h00, 3'd5);
        ins_b = mk(9'h000, 4'b0011, 8'h05, 8'h2D, 8'h00, 8'h00, 3'd6);
        model_expect(ins, ed, el, ea);
        start(ins, 1'b1);
        in_instr = ins_b;
        collect(ins, ed, el, ea, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_accept", 64'(busy), 64'd1);
        model_expect(ins_b, ed, el, ea);
        chk("b2b_model_sees_a", 64'(ed), 64'h019A);
        collect(ins_b, ed, el, ea, 0);

        // Reset during EXEC: no writeback, everything cleared
        ins = mk(9'h003, 4'b0000, 8'h55, 8'h66, 8'h00, 8'h00, 3'd4);
        start(ins, 1'b0);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", 64'(res_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            chk($sformatf("midrst_reg%0d", r), 64'(dbg_data), 64'd0);
            m_regs[r] = '0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_in_ready", 64'(in_ready), 64'd1);
        chk("postrst_res_valid", 64'(res_valid), 64'd0);

        // Recovery after reset
        ins = mk(9'h001, 4'b0100, 8'd3, 8'd5, 8'd4, 8'd7, 3'd4);
        model_expect(ins, ed, el, ea);
        start(ins, 1'b0);
        collect(ins, ed, el, ea, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
